// File: rtl/batt_mon_pkg.sv
// batt_mon_pkg
//   Shared types and default constants for the battery-voltage monitor.
//   bm_state_t      : low-battery FSM states (NORMAL, LOW)
//   BM_AVG_LOG2     : default log2 of samples per average
//   BM_LOW_THRESH   : default "battery low" threshold on the average
//   BM_HYST         : default hysteresis added to form the recovery threshold
//   BM_CONFIRM      : default number of consecutive qualifying averages
package batt_mon_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        LOW    = 1'b1
    } bm_state_t;

    localparam int          BM_AVG_LOG2   = 3;
    localparam logic [11:0] BM_LOW_THRESH = 12'h900;
    localparam logic [11:0] BM_HYST       = 12'h040;
    localparam int          BM_CONFIRM    = 3;

endpackage

// File: rtl/batt_mon_if.sv
// batt_mon_if
//   Groups the sample stream and the monitor results into one bundle.
//   batt      : 12-bit battery A2D sample
//   batt_vld  : batt is valid this cycle
//   batt_low  : registered level, 1 = battery low
//   avg       : most recent completed average
//   avg_vld   : one-cycle pulse when avg updates
//   master    : sample source / result consumer
//   slave     : the monitor itself
interface batt_mon_if;
    import batt_mon_pkg::*;

    logic [11:0] batt;
    logic        batt_vld;
    logic        batt_low;
    logic [11:0] avg;
    logic        avg_vld;

    modport master (
        output batt, batt_vld,
        input  batt_low, avg, avg_vld
    );

    modport slave (
        input  batt, batt_vld,
        output batt_low, avg, avg_vld
    );

endinterface

// File: rtl/batt_avg.sv
// batt_avg
//   Averages 2**AVG_LOG2 valid samples and publishes the truncated mean.
//   clk, rst_n : clock, asynchronous active-low reset
//   batt       : 12-bit unsigned sample
//   batt_vld   : sample valid, gaps allowed
//   avg        : most recent completed average (registered)
//   avg_vld    : one-cycle pulse when avg updates
module batt_avg
    import batt_mon_pkg::*;
#(
    parameter int AVG_LOG2 = BM_AVG_LOG2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] batt,
    input  logic        batt_vld,
    output logic [11:0] avg,
    output logic        avg_vld
);

    localparam int ACC_W = 12 + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic [AVG_LOG2-1:0] cnt;

    // Including the current sample in the sum lets the completing sample
    // land in the average on the same edge; 12+AVG_LOG2 bits hold a full
    // window of 12'hFFF without overflow.
    assign sum = acc + {{AVG_LOG2{1'b0}}, batt};

    // Accumulate valid samples; on the window's last sample publish the
    // mean and restart from zero so the next cycle begins a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            avg     <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (batt_vld) begin
                if (&cnt) begin
                    avg     <= sum[ACC_W-1:AVG_LOG2];
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/batt_mon.sv
// batt_mon
//   Battery-voltage monitor: windowed average, threshold with hysteresis
//   and multi-average confirmation, driving the low-battery level.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : batt_mon_if.slave (batt, batt_vld in; batt_low, avg,
//                avg_vld out)
module batt_mon
    import batt_mon_pkg::*;
#(
    parameter int          AVG_LOG2   = BM_AVG_LOG2,
    parameter logic [11:0] LOW_THRESH = BM_LOW_THRESH,
    parameter logic [11:0] HYST       = BM_HYST,
    parameter int          CONFIRM    = BM_CONFIRM
) (
    input  logic       clk,
    input  logic       rst_n,
    batt_mon_if.slave  bus
);

    // Recovery threshold is formed in 13 bits so a large HYST saturates
    // at full scale instead of wrapping to a tiny value.
    localparam logic [12:0] REC_SUM    = {1'b0, LOW_THRESH} + {1'b0, HYST};
    localparam logic [11:0] REC_THRESH = REC_SUM[12] ? 12'hFFF : REC_SUM[11:0];
    localparam logic [2:0]  CONFIRM_N  = 3'(CONFIRM);

    logic [11:0] avg;
    logic        avg_vld;
    bm_state_t   state;
    logic [2:0]  conf_cnt;
    logic [2:0]  conf_next;
    logic        batt_low_q;
    logic        below_thresh;
    logic        recovered;

    batt_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .batt     (bus.batt),
        .batt_vld (bus.batt_vld),
        .avg      (avg),
        .avg_vld  (avg_vld)
    );

    assign below_thresh = (avg < LOW_THRESH);
    assign recovered    = (avg >= REC_THRESH);
    assign conf_next    = conf_cnt + 3'd1;

    // The FSM only moves on avg_vld, so batt_low is stable between
    // averages. A non-qualifying average (including one inside the
    // hysteresis band while LOW) resets the confirmation run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            conf_cnt   <= 3'd0;
            batt_low_q <= 1'b0;
        end else if (avg_vld) begin
            case (state)
                NORMAL: begin
                    if (below_thresh) begin
                        if (conf_next == CONFIRM_N) begin
                            state      <= LOW;
                            batt_low_q <= 1'b1;
                            conf_cnt   <= 3'd0;
                        end else begin
                            conf_cnt <= conf_next;
                        end
                    end else begin
                        conf_cnt <= 3'd0;
                    end
                end
                LOW: begin
                    if (recovered) begin
                        if (conf_next == CONFIRM_N) begin
                            state      <= NORMAL;
                            batt_low_q <= 1'b0;
                            conf_cnt   <= 3'd0;
                        end else begin
                            conf_cnt <= conf_next;
                        end
                    end else begin
                        conf_cnt <= 3'd0;
                    end
                end
                default: begin
                    state      <= NORMAL;
                    batt_low_q <= 1'b0;
                    conf_cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.avg      = avg;
    assign bus.avg_vld  = avg_vld;
    assign bus.batt_low = batt_low_q;

endmodule
